// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: funct codes, ALU/forward encodings and the
// EX/MEM bundle layout consumed by both the EX and MEM stages.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10,
        ALU_OP_OR    = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_IDEX     = 2'b00,
        FWD_WB       = 2'b01,
        FWD_MEM      = 2'b10,
        FWD_IDEX_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam int EXM_W      = 107;
    localparam int EXM_WR_LSB = 105;
    localparam int EXM_WR_W   = 2;
    localparam int EXM_MEM_LSB = 102;
    localparam int EXM_MEM_W  = 3;
    localparam int EXM_BT_LSB = 70;
    localparam int EXM_ZERO   = 69;
    localparam int EXM_ALU_LSB = 37;
    localparam int EXM_SD_LSB = 5;
    localparam int EXM_RD_LSB = 0;
    localparam int EXM_RD_W   = 5;

    // mult, multu, div, divu occupy funct 0x18..0x1B
    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply (shift-add) / divide (restoring) with HI/LO.
// One iteration per cycle; signed operations run on magnitudes and fix signs at the end.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        acc_hi_p1, acc_lo_p1, dvs_p1, dvd_p1;
    logic               op_p1, neg_q_p1, neg_r_p1, div0_p1;

    logic               a_neg, b_neg, last_step, div_ge;
    logic [31:0]        a_mag, b_mag, step_hi, step_lo, div_diff, res_hi, res_lo;
    logic [32:0]        mul_sum, div_shift;
    logic [63:0]        mul_res;

    function automatic logic [31:0] cneg32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign a_neg     = is_signed & a[31];
    assign b_neg     = is_signed & b[31];
    assign a_mag     = cneg32(a_neg, a);
    assign b_mag     = cneg32(b_neg, b);
    assign last_step = (cnt_q == CNT_W'(1));

    // one iteration: acc_hi holds partial product / remainder, acc_lo multiplier / quotient
    always_comb begin
        mul_sum   = {1'b0, acc_hi_p1} + (acc_lo_p1[0] ? {1'b0, dvs_p1} : 33'd0);
        div_shift = {acc_hi_p1, acc_lo_p1[31]};
        div_ge    = div_shift >= {1'b0, dvs_p1};
        div_diff  = div_shift[31:0] - dvs_p1;
        if (op_p1) begin
            step_hi = div_ge ? div_diff : div_shift[31:0];
            step_lo = {acc_lo_p1[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo_p1[31:1]};
        end
        mul_res = neg_q_p1 ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};
        if (!op_p1) begin
            res_hi = mul_res[63:32];
            res_lo = mul_res[31:0];
        end else if (div0_p1) begin
            res_hi = dvd_p1;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = cneg32(neg_r_p1, step_hi);
            res_lo = cneg32(neg_q_p1, step_lo);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_BUSY;
            MD_BUSY: if (last_step) state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MD_IDLE && start)
                cnt_q <= CNT_W'(MD_CYCLES);
            else if (state_q == MD_BUSY)
                cnt_q <= cnt_q - CNT_W'(1);
            if (state_q == MD_BUSY && last_step) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    // operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (state_q == MD_IDLE && start) begin
            op_p1     <= op;
            neg_q_p1  <= a_neg ^ b_neg;
            neg_r_p1  <= a_neg;
            div0_p1   <= (b == 32'd0);
            dvd_p1    <= a;
            dvs_p1    <= b_mag;
            acc_hi_p1 <= '0;
            acc_lo_p1 <= a_mag;
        end else if (state_q == MD_BUSY) begin
            acc_hi_p1 <= step_hi;
            acc_lo_p1 <= step_lo;
        end
    end

    assign busy = (state_q == MD_BUSY);
    assign done = (state_q == MD_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, branch target and EX/MEM register.
// Mult/div hardware is built only when EX_STAGE_MULDIV_EN is defined.
module ex_stage
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   id_ex_rt,
    input  logic [4:0]   id_ex_rd,
    input  logic [31:0]  id_ex_ext,
    input  logic [31:0]  id_ex_data1,
    input  logic [31:0]  id_ex_data2,
    input  logic [31:0]  id_ex_pc_4,
    input  logic [3:0]   id_ex_ex_con,
    input  logic [2:0]   id_ex_mem_con,
    input  logic [1:0]   id_ex_wr_con,
    input  logic [1:0]   fwd_a,
    input  logic [1:0]   fwd_b,
    input  logic [31:0]  wb_data,
    input  logic [31:0]  ex_mem_fwd,
    output logic         stall,
    output logic [106:0] ex_mem_out
);

    logic [5:0]       funct;
    logic [31:0]      op_a, fwd_b_val, op_b, alu_res, br_tgt, hi, lo;
    logic [4:0]       dest;
    logic             md_present;
    logic [EXM_W-1:0] ex_mem_p0, ex_mem_p1;

    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] idex,
                                            input logic [31:0] wb, input logic [31:0] mem);
        case (sel)
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return idex;
        endcase
    endfunction

    assign funct      = id_ex_ext[5:0];
    assign md_present = (id_ex_ex_con[2:1] == ALU_OP_FUNCT) && is_muldiv(funct);
    assign op_a       = fwd_mux(fwd_a, id_ex_data1, wb_data, ex_mem_fwd);
    assign fwd_b_val  = fwd_mux(fwd_b, id_ex_data2, wb_data, ex_mem_fwd);
    assign op_b       = id_ex_ex_con[0] ? id_ex_ext : fwd_b_val;
    assign dest       = id_ex_ex_con[3] ? id_ex_rd : id_ex_rt;
    assign br_tgt     = id_ex_pc_4 + {id_ex_ext[29:0], 2'b00};

`ifdef EX_STAGE_MULDIV_EN
    logic md_busy, md_done;

    muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_present),
        .is_signed (~funct[0]),
        .op        (funct[1]),
        .a         (op_a),
        .b         (fwd_b_val),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (hi),
        .lo        (lo)
    );

    // stall is forced low while reset is asserted, even if a mult/div sits in ID/EX
    assign stall = !rst && (md_busy || (!md_done && md_present));
`else
    logic [31:0] unused_md_cycles;

    assign unused_md_cycles = 32'(MD_CYCLES);
    assign hi    = '0;
    assign lo    = '0;
    assign stall = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (id_ex_ex_con[2:1])
            ALU_OP_ADD: alu_res = op_a + op_b;
            ALU_OP_SUB: alu_res = op_a - op_b;
            ALU_OP_OR:  alu_res = op_a | op_b;
            default: begin
                case (funct)
                    FUNCT_ADD:  alu_res = op_a + op_b;
                    FUNCT_SUB:  alu_res = op_a - op_b;
                    FUNCT_AND:  alu_res = op_a & op_b;
                    FUNCT_OR:   alu_res = op_a | op_b;
                    FUNCT_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
                    FUNCT_MFHI: alu_res = hi;
                    FUNCT_MFLO: alu_res = lo;
                    default:    alu_res = '0;
                endcase
            end
        endcase
    end

    // stage boundary: EX -> EX/MEM; mult/div occupancy leaves a bubble
    always_comb begin
        ex_mem_p0 = '0;
        ex_mem_p0[EXM_WR_LSB  +: EXM_WR_W]  = md_present ? '0 : id_ex_wr_con;
        ex_mem_p0[EXM_MEM_LSB +: EXM_MEM_W] = md_present ? '0 : id_ex_mem_con;
        ex_mem_p0[EXM_BT_LSB  +: 32]        = br_tgt;
        ex_mem_p0[EXM_ZERO]                 = (alu_res == 32'd0);
        ex_mem_p0[EXM_ALU_LSB +: 32]        = alu_res;
        ex_mem_p0[EXM_SD_LSB  +: 32]        = fwd_b_val;
        ex_mem_p0[EXM_RD_LSB  +: EXM_RD_W]  = dest;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_mem_p1 <= '0;
        else     ex_mem_p1 <= ex_mem_p0;
    end

    assign ex_mem_out = ex_mem_p1;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EX register fields, applies operand forwarding, and performs ALU, branch-target and iterative multiply/divide operations. It registers the result into the packed EX/MEM bundle. Multiply and divide run for 32+ cycles, during which the block stalls the front of the pipeline and issues bubbles downstream.

## Interface
Parameters
- `MD_CYCLES`, default 32: iterations of the multiply/divide core. Fixed at 32 for 32-bit operands.

Ports
- `clk` in 1: pipeline clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_ex_rt`, `id_ex_rd` in 5: register specifiers.
- `id_ex_ext` in 32: sign-extended immediate; `[5:0]` is funct.
- `id_ex_data1`, `id_ex_data2` in 32: register-file operands A and B.
- `id_ex_pc_4` in 32: PC+4 of the instruction.
- `id_ex_ex_con` in 4: `[3]` reg_dst, `[2:1]` alu_op, `[0]` alu_src.
- `id_ex_mem_con` in 3 and `id_ex_wr_con` in 2: passed through.
- `fwd_a`, `fwd_b` in 2: forwarding select. 00 = ID/EX data, 01 = `wb_data`, 10 = `ex_mem_fwd`, 11 = ID/EX data.
- `wb_data`, `ex_mem_fwd` in 32: forwarded values.
- `stall` out 1: freezes PC, IF/ID and ID/EX. Combinational.
- `ex_mem_out` out 107: registered bundle with these fields:
  - `[106:105]` wr_con
  - `[104:102]` mem_con
  - `[101:70]` branch target
  - `[69]` zero
  - `[68:37]` alu result
  - `[36:5]` store data (forwarded B)
  - `[4:0]` destination register

## Operation
- Operand A is selected by `fwd_a`. Forwarded B is selected by `fwd_b`. ALU operand B is `id_ex_ext` when alu_src is 1, else forwarded B.
- Destination register is `id_ex_rd` when reg_dst is 1, else `id_ex_rt`.
- Branch target is `id_ex_pc_4 + (id_ex_ext << 2)`, mod 2^32.
- zero is 1 when the ALU result is 0.
- ALU operation by alu_op:
  - 00: add.
  - 01: sub.
  - 11: or (ori).
  - 10: decode funct:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
    - 0x2A slt, signed compare, result 1 or 0.
    - 0x10 mfhi, 0x12 mflo.
    - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu (the mult/div group).
    - Other funct values give result 0.
- All adds are 32-bit wrapping. There is no overflow trap.
- Multiply/divide FSM states:
  - IDLE: when a mult/div-group instruction is present, latch operands, load the counter with `MD_CYCLES`, and go to BUSY.
  - BUSY: one shift-add or restoring-subtract step per cycle. When the counter reaches 0, write HI/LO and go to DONE.
  - DONE: go to IDLE.
- Signed mult/div works on magnitudes.
  - Product sign is the XOR of the operand signs.
  - Quotient sign is the XOR of the operand signs; the remainder takes the dividend's sign.
- Divide by zero gives LO = 0xFFFF_FFFF and HI = dividend, with no exception.
- Mult/div instructions never write the register file. Every cycle they occupy EX emits a bubble.
- A bubble is `ex_mem_out` with wr_con = 0 and mem_con = 0; the other fields are don't-care but deterministic.

## Timing
- ALU ops have 1-cycle latency: ID/EX fields in cycle N appear on `ex_mem_out` after the edge ending cycle N.
- `stall` = (IDLE and mult/div present) or BUSY. It is low in DONE.
- Mult/div sequence:
  - Total stall is `MD_CYCLES`+1 cycles.
  - DONE lasts 1 cycle; the ID/EX register advances at the end of DONE.
  - HI/LO are valid from DONE onward.
  - An mfhi immediately after a mult reads the new value with no extra stall.
- HI/LO update only at the BUSY→DONE transition.
- Reset, including reset mid-BUSY, immediately forces:
  - FSM to IDLE, counter 0, `stall` = 0;
  - HI = LO = 0;
  - `ex_mem_out` = all zeros (a bubble).
  - The aborted operation does not update HI/LO.
- Forward selects and data are sampled in the same cycle as the ID/EX fields.

## Configuration
- `EX_STAGE_MULDIV_EN` defined: FSM, HI/LO and `stall` logic are present as described.
- `EX_STAGE_MULDIV_EN` undefined:
  - Mult/div funct codes produce a bubble with no state change.
  - `stall` is tied to 0.
  - mfhi/mflo return 0.
  - No HI/LO registers or sequential logic are synthesized except the EX/MEM register.

## Structure
- Shared package `mips_pkg` holds:
  - funct constants;
  - alu_op encodings;
  - forward-select encodings;
  - `ex_mem_out` field offsets and widths, which are shared with the MEM stage.
- One sub-module, `muldiv_unit`, contains the FSM, counter, and HI/LO registers. Its interface is start, signed, op, a, b, busy, done, hi, lo.

## Test plan
- add with data1 = 5, data2 = 7, funct 0x20, rd = 3 → next cycle alu result 12, dest 3, zero = 0, wr_con passed through.
- beq-style: alu_op 01, data1 = data2 = 9, pc_4 = 0x100, ext = 4 → zero = 1, branch target 0x110.
- `fwd_a` = 10 with `ex_mem_fwd` = 0x20 and data1 = 0 → operand A = 0x20. slt against B = −1 gives 0.
- mult with 0xFFFF_FFFE × 3 (signed):
  - `stall` high for 33 cycles;
  - bubbles emitted;
  - HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA;
  - a following mflo returns 0xFFFF_FFFA.
- divu 7/0 → LO = 0xFFFF_FFFF, HI = 7. Separately, divu 100/7 → LO = 14, HI = 2.
- Assert `rst` at BUSY cycle 10 → `stall` drops immediately, `ex_mem_out` = 0, HI/LO = 0; after release, an add completes normally.
